// File: rtl/threat_report_arbiter.sv
// Two per-direction threat record FIFOs drained round-robin into one registered 128-bit host channel.
// Optional THREAT_DEDUP_EN: discard a req identical (bits [98:0]) to the last record pushed by that source.
module threat_report_arbiter #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             req1_valid,
  input  logic [127:0]     req1_data,
  input  logic             req2_valid,
  input  logic [127:0]     req2_data,
  output logic             out_valid,
  output logic [127:0]     out_data,
  input  logic             out_ready,
  output logic             fifo1_full,
  output logic             fifo2_full,
  output logic [CNT_W-1:0] drop_cnt1,
  output logic [CNT_W-1:0] drop_cnt2,
  output logic             dbg_state
);

  // Output handshake: a record moves to the host on a rising edge where
  // out_valid and out_ready are both high; out_data is stable while out_valid
  // is high and out_ready is low.

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]    PTR_ONE = PW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state_q;
  logic               out_valid_q;
  logic [127:0]       out_data_q;
  logic               last_grant_q;

  logic [127:0]       mem1_q [DEPTH];
  logic [127:0]       mem2_q [DEPTH];
  logic [PW-1:0]      wr1_q, rd1_q;
  logic [PW-1:0]      wr2_q, rd2_q;
  logic [CNT_W-1:0]   drop1_q, drop2_q;

  logic               empty1, empty2;
  logic               full1, full2;
  logic               dup1, dup2;
  logic               accept1, accept2;
  logic               push1, push2;
  logic               drop1, drop2;
  logic               can_load;
  logic               any_ne;
  logic               grant2;
  logic               pop, pop1, pop2;
  logic [127:0]       head1, head2;
  logic [127:0]       grant_data;

  assign empty1 = (wr1_q == rd1_q);
  assign empty2 = (wr2_q == rd2_q);
  assign full1  = (wr1_q[AW] != rd1_q[AW]) && (wr1_q[AW-1:0] == rd1_q[AW-1:0]);
  assign full2  = (wr2_q[AW] != rd2_q[AW]) && (wr2_q[AW-1:0] == rd2_q[AW-1:0]);

`ifdef THREAT_DEDUP_EN
  logic [98:0] last1_q, last2_q;
  logic        last1_vld_q, last2_vld_q;

  assign dup1 = last1_vld_q && (req1_data[98:0] == last1_q);
  assign dup2 = last2_vld_q && (req2_data[98:0] == last2_q);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last1_q     <= '0;
      last2_q     <= '0;
      last1_vld_q <= 1'b0;
      last2_vld_q <= 1'b0;
    end else begin
      if (push1) begin
        last1_q     <= req1_data[98:0];
        last1_vld_q <= 1'b1;
      end
      if (push2) begin
        last2_q     <= req2_data[98:0];
        last2_vld_q <= 1'b1;
      end
    end
  end
`else
  assign dup1 = 1'b0;
  assign dup2 = 1'b0;
`endif

  // Fullness is judged at the start of the cycle, so a same-cycle pop never frees a slot.
  assign accept1 = req1_valid && !dup1;
  assign accept2 = req2_valid && !dup2;
  assign push1   = accept1 && !full1;
  assign push2   = accept2 && !full2;
  assign drop1   = accept1 && full1;
  assign drop2   = accept2 && full2;

  assign head1 = mem1_q[rd1_q[AW-1:0]];
  assign head2 = mem2_q[rd2_q[AW-1:0]];

  // last_grant_q: 0 = source 1 popped last, 1 = source 2 popped last.
  assign any_ne     = !empty1 || !empty2;
  assign grant2     = !empty2 && (empty1 || !last_grant_q);
  assign can_load   = (state_q == IDLE) || out_ready;
  assign pop        = can_load && any_ne;
  assign pop1       = pop && !grant2;
  assign pop2       = pop && grant2;
  assign grant_data = grant2 ? head2 : head1;

  always_ff @(posedge clk) begin
    if (push1) begin
      mem1_q[wr1_q[AW-1:0]] <= req1_data;
    end
    if (push2) begin
      mem2_q[wr2_q[AW-1:0]] <= req2_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr1_q <= '0;
      rd1_q <= '0;
      wr2_q <= '0;
      rd2_q <= '0;
    end else begin
      if (push1) begin
        wr1_q <= wr1_q + PTR_ONE;
      end
      if (pop1) begin
        rd1_q <= rd1_q + PTR_ONE;
      end
      if (push2) begin
        wr2_q <= wr2_q + PTR_ONE;
      end
      if (pop2) begin
        rd2_q <= rd2_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      drop1_q <= '0;
      drop2_q <= '0;
    end else begin
      if (drop1 && (drop1_q != CNT_MAX)) begin
        drop1_q <= drop1_q + CNT_ONE;
      end
      if (drop2 && (drop2_q != CNT_MAX)) begin
        drop2_q <= drop2_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      if (pop) begin
        last_grant_q <= grant2;
      end
      case (state_q)
        IDLE: begin
          if (any_ne) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            out_data_q  <= grant_data;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (any_ne) begin
              out_data_q <= grant_data;
            end else begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign fifo1_full = full1;
  assign fifo2_full = full2;
  assign drop_cnt1  = drop1_q;
  assign drop_cnt2  = drop2_q;
  assign dbg_state  = (state_q == HOLD);

endmodule

// File: tb/tb_threat_report_arbiter.sv
// Directed bench for threat_report_arbiter: latency, tie order, backpressure, fairness, saturation, async reset, dedup.
module tb_threat_report_arbiter;

  logic         clk;
  logic         n_rst;
  logic         req1_valid;
  logic [127:0] req1_data;
  logic         req2_valid;
  logic [127:0] req2_data;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_ready;
  logic         fifo1_full;
  logic         fifo2_full;
  logic [7:0]   drop_cnt1;
  logic [7:0]   drop_cnt2;
  logic         dbg_state;

  logic [127:0] exp_q[$];
  int           n_checks;
  int           n_fail;

  localparam logic [127:0] D1 = 128'h00000001_0003_AABBCCDDEEFF_C0A80001;

  threat_report_arbiter #(.DEPTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req2_valid (req2_valid),
    .req2_data  (req2_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .fifo1_full (fifo1_full),
    .fifo2_full (fifo2_full),
    .drop_cnt1  (drop_cnt1),
    .drop_cnt2  (drop_cnt2),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [127:0] mk(input int i);
    mk = {16'h0, 8'h01, 5'h0, 3'(i), 16'(i), 48'hA0B0_C0D0_0000 + 48'(i), 32'hC0A8_0000 + 32'(i)};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge, outputs are sampled there too.
  task automatic do_reset();
    n_rst      = 1'b0;
    req1_valid = 1'b0;
    req2_valid = 1'b0;
    req1_data  = '0;
    req2_data  = '0;
    out_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < max_cyc) begin
      if (out_valid) begin
        check(tag, out_data, exp_q.pop_front());
      end
      @(negedge clk);
      n++;
    end
    check({tag, "_left"}, 128'(exp_q.size()), 128'd0);
    check({tag, "_idle"}, 128'(out_valid), 128'd0);
  endtask

  int out_cnt;

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset state
    n_rst      = 1'b0;
    req1_valid = 1'b0;
    req2_valid = 1'b0;
    req1_data  = '0;
    req2_data  = '0;
    out_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_full1", 128'(fifo1_full), 128'd0);
    check("rst_full2", 128'(fifo2_full), 128'd0);
    check("rst_drop1", 128'(drop_cnt1), 128'd0);
    check("rst_drop2", 128'(drop_cnt2), 128'd0);
    check("rst_state", 128'(dbg_state), 128'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // Single event: visible after the second edge, one cycle, then zeroed
    out_ready  = 1'b1;
    req1_valid = 1'b1;
    req1_data  = D1;
    @(negedge clk);
    req1_valid = 1'b0;
    check("t1_valid_edge_n", 128'(out_valid), 128'd0);
    @(negedge clk);
    check("t1_valid", 128'(out_valid), 128'd1);
    check("t1_data", out_data, D1);
    check("t1_state_hold", 128'(dbg_state), 128'd1);
    @(negedge clk);
    check("t1_idle_valid", 128'(out_valid), 128'd0);
    check("t1_idle_data", out_data, 128'd0);

    // Simultaneous events: source 1 wins the first tie after reset
    do_reset();
    out_ready  = 1'b1;
    req1_valid = 1'b1;
    req1_data  = mk(1);
    req2_valid = 1'b1;
    req2_data  = mk(2);
    @(negedge clk);
    req1_valid = 1'b0;
    req2_valid = 1'b0;
    @(negedge clk);
    check("t2_first_valid", 128'(out_valid), 128'd1);
    check("t2_first_data", out_data, mk(1));
    @(negedge clk);
    check("t2_second_valid", 128'(out_valid), 128'd1);
    check("t2_second_data", out_data, mk(2));
    @(negedge clk);
    check("t2_idle", 128'(out_valid), 128'd0);
    check("t2_drop1", 128'(drop_cnt1), 128'd0);
    check("t2_drop2", 128'(drop_cnt2), 128'd0);

    // Backpressure: output register holds record 1, FIFO fills with 2..5
    do_reset();
    exp_q.delete();
    for (int i = 1; i <= 5; i++) begin
      req1_valid = 1'b1;
      req1_data  = mk(i);
      exp_q.push_back(mk(i));
      @(negedge clk);
    end
    req1_valid = 1'b0;
    check("t3_hold_data", out_data, mk(1));
    check("t3_full1", 128'(fifo1_full), 128'd1);
    check("t3_drop1_zero", 128'(drop_cnt1), 128'd0);
    req1_valid = 1'b1;
    req1_data  = mk(6);
    @(negedge clk);
    req1_valid = 1'b0;
    check("t3_drop1_one", 128'(drop_cnt1), 128'd1);
    check("t3_still_held", out_data, mk(1));
    drain("t3_order", 20);

    // Fairness: both FIFOs full, grants alternate
    do_reset();
    exp_q.delete();
    for (int i = 1; i <= 5; i++) begin
      req1_valid = 1'b1;
      req1_data  = mk(10 + i);
      req2_valid = (i <= 4);
      req2_data  = mk(20 + i);
      @(negedge clk);
    end
    req1_valid = 1'b0;
    req2_valid = 1'b0;
    check("t4_full1", 128'(fifo1_full), 128'd1);
    check("t4_full2", 128'(fifo2_full), 128'd1);
    check("t4_drop1", 128'(drop_cnt1), 128'd0);
    check("t4_drop2", 128'(drop_cnt2), 128'd0);
    exp_q.push_back(mk(11));
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(mk(20 + i));
      exp_q.push_back(mk(11 + i));
    end
    drain("t4_order", 30);

    // Saturation: 305 strobes with the output stalled -> 300 drops, capped at 255
    do_reset();
    for (int i = 1; i <= 105; i++) begin
      req2_valid = 1'b1;
      req2_data  = mk(30 + i);
      @(negedge clk);
    end
    check("t5_drop2_100", 128'(drop_cnt2), 128'd100);
    check("t5_full2", 128'(fifo2_full), 128'd1);
    check("t5_head", out_data, mk(31));
    for (int i = 106; i <= 260; i++) begin
      req2_data = mk(30 + i);
      @(negedge clk);
    end
    check("t5_drop2_255", 128'(drop_cnt2), 128'd255);
    for (int i = 261; i <= 305; i++) begin
      req2_data = mk(30 + i);
      @(negedge clk);
    end
    check("t5_drop2_sat", 128'(drop_cnt2), 128'd255);
    check("t5_drop1", 128'(drop_cnt1), 128'd0);

    // Asynchronous reset mid-burst, away from any clock edge
    #2;
    n_rst = 1'b0;
    #1;
    check("t5_arst_valid", 128'(out_valid), 128'd0);
    check("t5_arst_data", out_data, 128'd0);
    check("t5_arst_drop2", 128'(drop_cnt2), 128'd0);
    check("t5_arst_full2", 128'(fifo2_full), 128'd0);
    req2_valid = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("t5_post_valid", 128'(out_valid), 128'd0);

    // Dedup: same record three times then a new one
    do_reset();
    out_ready = 1'b1;
    out_cnt   = 0;
    for (int i = 0; i < 4; i++) begin
      req1_valid = 1'b1;
      req1_data  = (i < 3) ? D1 : mk(40);
      @(negedge clk);
      if (out_valid) out_cnt++;
    end
    req1_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) out_cnt++;
    end
`ifdef THREAT_DEDUP_EN
    check("t6_outputs", 128'(out_cnt), 128'd2);
`else
    check("t6_outputs", 128'(out_cnt), 128'd4);
`endif
    check("t6_drop1", 128'(drop_cnt1), 128'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/threat_report_arbiter.md
Name: threat_report_arbiter

Overview:
Sits between the two direction-specific threat record sources and the single 128-bit host report channel. Each source (phy1->phy2 close events, phy2->phy1 close events) gets its own small FIFO, so simultaneous events are never lost to fixed priority. A round-robin arbiter drains both FIFOs into a registered valid/ready output stage. Overflow drops are counted per source for host visibility.

Parameters:
DEPTH, 4, entries per source FIFO; power of two, minimum 2.
CNT_W, 8, width of the saturating drop counters.

Ports:
clk  input  1  system clock; all logic on rising edge.
n_rst  input  1  asynchronous active-low reset.
req1_valid  input  1  single-cycle strobe: phy1->phy2 threat record present.
req1_data  input  128  phy1 record: [31:0] ip, [79:32] mac, [95:80] port, [98:96] threat flags, [111:104] direction code, rest 0.
req2_valid  input  1  single-cycle strobe: phy2->phy1 threat record present.
req2_data  input  128  phy2 record, same layout.
out_valid  output  1  out_data holds a record for the host.
out_data  output  128  granted record.
out_ready  input  1  host accepts out_data this cycle.
fifo1_full  output  1  source-1 FIFO holds DEPTH entries.
fifo2_full  output  1  source-2 FIFO holds DEPTH entries.
drop_cnt1  output  CNT_W  records lost on source 1, saturating.
drop_cnt2  output  CNT_W  records lost on source 2, saturating.

Behaviour:
- Reset (async, n_rst low): all outputs 0; FIFOs empty; pointers 0; last_grant = source 2, so source 1 wins the first tie; FSM = IDLE.
- Push: req_valid with FIFO not full at the start of the cycle -> write at the edge; occupancy +1.
- Full FIFO: the record is dropped and drop_cnt +1. The counter holds at 2^CNT_W-1. A pop in the same cycle does not make room; there is no pass-through.
- Pointers: log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty; wrap is natural.
- FSM, two states:
  - IDLE: out_valid=0. If any FIFO is non-empty: grant, pop, load the out register, go to HOLD.
  - HOLD: out_valid=1; out_data is stable until accepted.
    - out_ready=1 and a FIFO is non-empty: grant/pop/load in the same edge (back-to-back, 1 record per cycle), stay in HOLD.
    - out_ready=1 and both FIFOs empty: go to IDLE and clear out_data to 0.
    - out_ready=0: hold.
- Arbitration:
  - Only one FIFO non-empty: that FIFO is granted.
  - Both non-empty: grant the source other than last_grant.
  - last_grant updates only on an actual pop.
- Simultaneous push and pop on the same FIFO: both occur; occupancy is unchanged.
- Latency: req_valid sampled at edge N into an empty block -> out_valid high after edge N+1.
- fifo_full outputs are combinational from the pointers.
- Reset mid-operation: buffered and presented records are discarded; drop counters clear.

Optional Feature:
THREAT_DEDUP_EN.
- Defined: each source keeps a last-pushed record register and a valid bit, both cleared on reset. A req whose bits [98:0] equal the last pushed record is silently discarded: no push and no drop count.
- Not defined: every req is pushed or counted as a drop. The comparator and last-pushed registers are absent.

Test Plan:
- Single event: req1_valid with data 0x...0001_0003_AABBCCDDEEFF_C0A80001, out_ready=1 -> out_valid at edge N+1 with the identical 128 bits for one cycle, then IDLE with out_data=0.
- Simultaneous events: req1 and req2 in the same cycle, out_ready=1 -> source 1 record, then source 2 record on consecutive cycles; drop counters stay 0.
- Backpressure: out_ready=0, 5 req1 strobes with DEPTH=4 -> out holds record 1; FIFO1 keeps records 2-5, so fifo1_full=1; drop_cnt1=0. A 6th strobe -> drop_cnt1=1. Release out_ready -> records 1-5 in order.
- Fairness: both FIFOs full, out_ready=1 -> grants alternate 1,2,1,2... until both are empty.
- Saturation and reset: 300 drops on source 2 -> drop_cnt2=255. Assert n_rst mid-burst -> out_valid=0 and counters 0 immediately, without waiting for a clock edge.
- THREAT_DEDUP_EN: the same req1_data sent 3 times, then a different record -> exactly 2 outputs; drop_cnt1=0. Without the macro: 4 outputs.
